pipeline_stall_controller: RTL and testbench

Central stall/flush controller for the 5-stage ARM pipeline: it consumes the ID-stage `hazard_detected` flag, the EXE-stage `branch_taken`, and the MEM-stage SRAM/cache request/ready handshake. It produces the freeze, bubble and flush controls for the PC and the pipeline registers. A small FSM tracks memory waits and flags a stuck memory with a timeout. Saturating performance counters record stall and flush activity.

---
 rtl/pipeline_stall_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush controller with memory-wait FSM, timeout and saturating counters
// Combinational freeze/bubble/flush priority over a registered RUN/MEM_WAIT/TIMEOUT tracker.
module pipeline_stall_controller #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             freeze_front,
  output logic             freeze_back,
  output logic             bubble_id_ex,
  output logic             flush,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] hazard_cnt_q, mem_cnt_q, flush_cnt_q;

  logic miss;
  logic mem_hold;
  logic case_mem, case_br, case_hz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    miss     = mem_req & ~mem_ready;
    mem_hold = (state_q == TIMEOUT) | miss;
    case_mem = ~rst & mem_hold;
    case_br  = ~rst & ~mem_hold & branch_taken;
    case_hz  = ~rst & ~mem_hold & ~branch_taken & hazard_detected;

    freeze_front = case_mem | case_hz;
    freeze_back  = case_mem;
    bubble_id_ex = case_hz;
    flush        = case_br;
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (miss) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        // Ready wins over the timeout on the last permitted frozen cycle.
        if (mem_ready || !mem_req) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q + TO_W'(1) == TO_LIM) begin
          state_d       = TIMEOUT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      TIMEOUT: begin
        state_d = TIMEOUT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      hazard_cnt_q  <= '0;
      mem_cnt_q     <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      if (clr_cnt) begin
        hazard_cnt_q <= '0;
        mem_cnt_q    <= '0;
        flush_cnt_q  <= '0;
      end else begin
        if (case_hz)  hazard_cnt_q <= sat_inc(hazard_cnt_q);
        if (case_mem) mem_cnt_q    <= sat_inc(mem_cnt_q);
        if (case_br)  flush_cnt_q  <= sat_inc(flush_cnt_q);
      end
    end
  end

  // Registered outputs are also forced low while reset is held.
  assign mem_wait         = ~rst & (state_q != RUN);
  assign mem_timeout      = ~rst & mem_timeout_q;
  assign hazard_stall_cnt = rst ? '0 : hazard_cnt_q;
  assign mem_stall_cnt    = rst ? '0 : mem_cnt_q;
  assign flush_cnt        = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench with behavioural model and directed/random stimulus
module tb_pipeline_stall_controller;

  localparam int CNT_W   = 2;
  localparam int TO_CYC  = 4;
  localparam int TO_W    = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_req, mem_ready, clr_cnt;
  logic freeze_front, freeze_back, bubble_id_ex, flush, mem_wait, mem_timeout;
  logic [CNT_W-1:0] hazard_stall_cnt, mem_stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive frozen-miss run length, stuck flag, counters
  int m_run    = 0;
  bit m_stuck  = 0;
  int m_hz_cnt = 0;
  int m_mem_cnt = 0;
  int m_fl_cnt = 0;

  pipeline_stall_controller #(
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_front(freeze_front), .freeze_back(freeze_back), .bubble_id_ex(bubble_id_ex),
    .flush(flush), .mem_wait(mem_wait), .mem_timeout(mem_timeout),
    .hazard_stall_cnt(hazard_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Which priority case applies this cycle: 0 none, 1 mem freeze, 2 branch flush, 3 hazard
  function automatic int cur_case();
    bit miss;
    miss = mem_req && !mem_ready;
    if (rst) return 0;
    if (m_stuck || miss) return 1;
    if (branch_taken) return 2;
    if (hazard_detected) return 3;
    return 0;
  endfunction

  always @(negedge clk) begin
    int c;
    c = cur_case();
    chk("freeze_front", freeze_front, (c == 1 || c == 3));
    chk("freeze_back",  freeze_back,  (c == 1));
    chk("bubble_id_ex", bubble_id_ex, (c == 3));
    chk("flush",        flush,        (c == 2));
    chk("mem_wait",     mem_wait,     rst ? 0 : (m_stuck || m_run > 0));
    chk("mem_timeout",  mem_timeout,  rst ? 0 : m_stuck);
    chk("hazard_stall_cnt", hazard_stall_cnt, rst ? 0 : m_hz_cnt);
    chk("mem_stall_cnt",    mem_stall_cnt,    rst ? 0 : m_mem_cnt);
    chk("flush_cnt",        flush_cnt,        rst ? 0 : m_fl_cnt);
  end

  always @(posedge clk) begin
    int c;
    c = cur_case();
    if (rst) begin
      m_run = 0; m_stuck = 0; m_hz_cnt = 0; m_mem_cnt = 0; m_fl_cnt = 0;
    end else begin
      if (clr_cnt) begin
        m_hz_cnt = 0; m_mem_cnt = 0; m_fl_cnt = 0;
      end else begin
        if (c == 1 && m_mem_cnt < CNT_MAX) m_mem_cnt++;
        if (c == 2 && m_fl_cnt  < CNT_MAX) m_fl_cnt++;
        if (c == 3 && m_hz_cnt  < CNT_MAX) m_hz_cnt++;
      end
      if (!m_stuck) begin
        if (mem_req && !mem_ready) begin
          m_run++;
          if (m_run == TO_CYC) m_stuck = 1;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic h, input logic b,
                     input logic q, input logic y, input logic c);
    @(posedge clk);
    #1;
    rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y; clr_cnt = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; hazard_detected = 1; branch_taken = 1; mem_req = 1; mem_ready = 1; clr_cnt = 1;

    // Reset with all inputs high
    @(negedge clk);
    chk("lit_rst_freeze_front", freeze_front, 0);
    chk("lit_rst_flush", flush, 0);
    cyc(1, 1, 1, 1, 1, 1);
    chk("lit_rst_freeze_back", freeze_back, 0);
    chk("lit_rst_mem_wait", mem_wait, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_post_rst_mem_wait", mem_wait, 0);
    chk("lit_post_rst_hz_cnt", hazard_stall_cnt, 0);
    chk("lit_post_rst_fl_cnt", flush_cnt, 0);

    // Hazard only, two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("lit_hz_freeze_front", freeze_front, 1);
      chk("lit_hz_bubble", bubble_id_ex, 1);
      chk("lit_hz_freeze_back", freeze_back, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_hz_cnt2", hazard_stall_cnt, 2);

    // Branch beats hazard
    cyc(0, 1, 1, 0, 0, 0);
    chk("lit_br_flush", flush, 1);
    chk("lit_br_freeze_front", freeze_front, 0);
    chk("lit_br_bubble", bubble_id_ex, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_br_fl_cnt", flush_cnt, 1);
    chk("lit_br_hz_cnt", hazard_stall_cnt, 2);

    // Memory wait with a concurrent branch
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
      chk("lit_mw_freeze_front", freeze_front, 1);
      chk("lit_mw_freeze_back", freeze_back, 1);
      chk("lit_mw_flush", flush, 0);
      chk("lit_mw_mem_wait", mem_wait, (i >= 2));
    end
    cyc(0, 0, 1, 1, 1, 0);
    chk("lit_mw4_flush", flush, 1);
    chk("lit_mw4_mem_wait", mem_wait, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_mw_stall_cnt", mem_stall_cnt, 3);
    chk("lit_mw_fl_cnt", flush_cnt, 2);
    chk("lit_mw_done_wait", mem_wait, 0);

    // Timeout after four frozen cycles
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("lit_to_mem_timeout", mem_timeout, (i == 5));
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      chk("lit_to_stuck_front", freeze_front, 1);
      chk("lit_to_stuck_back", freeze_back, 1);
      chk("lit_to_stuck_flush", flush, 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("lit_to_rst_timeout", mem_timeout, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_to_cleared_timeout", mem_timeout, 0);
    chk("lit_to_cleared_freeze", freeze_back, 0);

    // Counter saturation and clear
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_sat_hz_cnt", hazard_stall_cnt, 3);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("lit_clr_hz_cnt", hazard_stall_cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
